// File: rtl/tag_ram_nway.sv
// N-way set-associative tag store: tag/valid/dirty per way, tree-PLRU per set, hardware invalidation sweep.
// Latency: lookup response registered 1 cycle after the accepting edge; fills/dirty updates visible next edge.
// Backpressure: none; lookups, fills and dirty updates are dropped while init_busy is high (2^SET_BITS-cycle sweep).
//
// Ports:
//   clk, reset (async, active-high)     - clocking; reset forces a fresh sweep from set 0
//   init_busy                           - sweep in progress
//   inv_all                             - pulse, starts a sweep (ignored while already sweeping)
//   req_valid/req_index/req_tag         - lookup request
//   rsp_valid/hit/way/victim/victim_*   - registered lookup response
//   fill_en/index/way/tag/dirty         - install a line
//   dirty_set_en/dirty_index/dirty_way  - mark an existing line dirty
// Optional feature: define TAG_RAM_BYPASS_EN so a lookup sees a same-edge fill to its set.
module tag_ram_nway #(
  parameter int  WAYS     = 4,
  parameter int  SET_BITS = 9,
  parameter int  TAG_W    = 18,
  localparam int WAY_W    = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_busy,
  input  logic                inv_all,
  input  logic                req_valid,
  input  logic [SET_BITS-1:0] req_index,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                rsp_valid,
  output logic                rsp_hit,
  output logic [WAY_W-1:0]    rsp_way,
  output logic [WAY_W-1:0]    rsp_victim,
  output logic                rsp_victim_valid,
  output logic                rsp_victim_dirty,
  output logic [TAG_W-1:0]    rsp_victim_tag,
  input  logic                fill_en,
  input  logic [SET_BITS-1:0] fill_index,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                fill_dirty,
  input  logic                dirty_set_en,
  input  logic [SET_BITS-1:0] dirty_index,
  input  logic [WAY_W-1:0]    dirty_way
);

  localparam int SETS = 1 << SET_BITS;
  localparam int PW   = WAYS - 1;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t              state_q;
  logic [SET_BITS-1:0] cnt_q;
  logic                busy_q;

  logic                rsp_valid_q;
  logic                rsp_hit_q;
  logic [WAY_W-1:0]    rsp_way_q;
  logic [WAY_W-1:0]    rsp_victim_q;
  logic                rsp_vvalid_q;
  logic                rsp_vdirty_q;
  logic [TAG_W-1:0]    rsp_vtag_q;

  // Tag store. Not reset: valid/dirty/PLRU are cleared by the sweep, and
  // tags of invalid ways are never meaningful.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [PW-1:0]    plru_q  [SETS];

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2
  // (upper half). Each bit names the LRU side, so touching a way sets the
  // path bits to the opposite half.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0]    p,
                                               input logic [WAY_W-1:0] w);
    logic [PW-1:0] r;
    int            node;
    logic          b;
    r    = p;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b       = w[WAY_W-1-lvl];
      r[node] = ~b;
      node    = 2 * node + (b ? 2 : 1);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] p);
    logic [WAY_W-1:0] v;
    int               node;
    v    = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      v[WAY_W-1-lvl] = p[node];
      node           = 2 * node + (p[node] ? 2 : 1);
    end
    return v;
  endfunction

  logic req_ok, fill_ok, dset_ok;
  assign req_ok  = req_valid    & ~busy_q;
  assign fill_ok = fill_en      & ~busy_q;
  assign dset_ok = dirty_set_en & ~busy_q;

  // View of the looked-up set as seen by the compare/victim logic.
  logic [WAYS-1:0]  lk_valid;
  logic [WAYS-1:0]  lk_dirty;
  logic [TAG_W-1:0] lk_tag [WAYS];
  logic [PW-1:0]    lk_plru;

  always_comb begin
    lk_valid = valid_q[req_index];
    lk_dirty = dirty_q[req_index];
    for (int w = 0; w < WAYS; w++) lk_tag[w] = tag_q[req_index][w];
    lk_plru  = plru_q[req_index];
`ifdef TAG_RAM_BYPASS_EN
    if (fill_ok && (fill_index == req_index)) begin
      lk_valid[fill_way] = 1'b1;
      lk_dirty[fill_way] = fill_dirty;
      lk_tag[fill_way]   = fill_tag;
      lk_plru            = plru_touch(lk_plru, fill_way);
    end
`endif
  end

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_any;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] vic_way;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_valid[w] && (lk_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!lk_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    vic_way = inv_any ? inv_way : plru_victim(lk_plru);
  end

  // Control FSM and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SWEEP;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
      rsp_vvalid_q <= 1'b0;
      rsp_vdirty_q <= 1'b0;
      rsp_vtag_q   <= '0;
    end else begin
      rsp_valid_q <= req_ok;
      if (req_ok) begin
        rsp_hit_q    <= hit;
        rsp_way_q    <= hit_way;
        rsp_victim_q <= vic_way;
        rsp_vvalid_q <= lk_valid[vic_way];
        rsp_vdirty_q <= lk_dirty[vic_way];
        rsp_vtag_q   <= lk_tag[vic_way];
      end
      if (state_q == ST_SWEEP) begin
        cnt_q <= cnt_q + SET_BITS'(1);
        if (cnt_q == '1) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      end else if (inv_all) begin
        state_q <= ST_SWEEP;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end
  end

  // Storage updates. Later assignments win: fill overrides dirty_set_en on
  // the same way, and a same-set fill replaces the hit's PLRU update.
  always_ff @(posedge clk) begin
    if (state_q == ST_SWEEP) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (req_ok && hit && !(fill_ok && (fill_index == req_index)))
        plru_q[req_index] <= plru_touch(lk_plru, hit_way);
      if (dset_ok)
        dirty_q[dirty_index][dirty_way] <= 1'b1;
      if (fill_ok) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        dirty_q[fill_index][fill_way] <= fill_dirty;
        tag_q[fill_index][fill_way]   <= fill_tag;
        plru_q[fill_index]            <= plru_touch(plru_q[fill_index], fill_way);
      end
    end
  end

  assign init_busy        = busy_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_victim       = rsp_victim_q;
  assign rsp_victim_valid = rsp_vvalid_q;
  assign rsp_victim_dirty = rsp_vdirty_q;
  assign rsp_victim_tag   = rsp_vtag_q;

endmodule

// File: tb/tb_tag_ram_nway.sv
// Bench for tag_ram_nway (WAYS=4, SET_BITS=9, TAG_W=18).
// Table rows drive lookup/fill/dirty ops one per cycle; expected responses go
// through a queue and are compared when the response cycle arrives.
module tb_tag_ram_nway;
  localparam int WAYS     = 4;
  localparam int SET_BITS = 9;
  localparam int TAG_W    = 18;
  localparam int WAY_W    = 2;
`ifdef TAG_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                init_busy;
  logic                inv_all = 1'b0;
  logic                req_valid = 1'b0;
  logic [SET_BITS-1:0] req_index = '0;
  logic [TAG_W-1:0]    req_tag = '0;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [WAY_W-1:0]    rsp_way;
  logic [WAY_W-1:0]    rsp_victim;
  logic                rsp_victim_valid;
  logic                rsp_victim_dirty;
  logic [TAG_W-1:0]    rsp_victim_tag;
  logic                fill_en = 1'b0;
  logic [SET_BITS-1:0] fill_index = '0;
  logic [WAY_W-1:0]    fill_way = '0;
  logic [TAG_W-1:0]    fill_tag = '0;
  logic                fill_dirty = 1'b0;
  logic                dirty_set_en = 1'b0;
  logic [SET_BITS-1:0] dirty_index = '0;
  logic [WAY_W-1:0]    dirty_way = '0;

  always #5 clk = ~clk;

  tag_ram_nway #(.WAYS(WAYS), .SET_BITS(SET_BITS), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy), .inv_all(inv_all),
    .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_victim(rsp_victim), .rsp_victim_valid(rsp_victim_valid),
    .rsp_victim_dirty(rsp_victim_dirty), .rsp_victim_tag(rsp_victim_tag),
    .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty),
    .dirty_set_en(dirty_set_en), .dirty_index(dirty_index), .dirty_way(dirty_way)
  );

  typedef struct {
    bit                  lk;
    logic [SET_BITS-1:0] li;
    logic [TAG_W-1:0]    lt;
    bit                  fl;
    logic [SET_BITS-1:0] fi;
    logic [WAY_W-1:0]    fw;
    logic [TAG_W-1:0]    ft;
    bit                  fd;
    bit                  ds;
    logic [SET_BITS-1:0] di;
    logic [WAY_W-1:0]    dw;
    bit                  hit;
    logic [WAY_W-1:0]    way;
    logic [WAY_W-1:0]    vic;
    bit                  vv;
    bit                  vd;
    logic [TAG_W-1:0]    vt;
  } vec_t;

  typedef struct {
    int               id;
    bit               hit;
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] vic;
    bit               vv;
    bit               vd;
    logic [TAG_W-1:0] vt;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   nb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  function automatic vec_t lk(input int i, input int t, input bit h, input int w,
                              input int vic, input bit vv, input bit vd, input int vt);
    vec_t v;
    v     = blank();
    v.lk  = 1'b1;
    v.li  = SET_BITS'(i);
    v.lt  = TAG_W'(t);
    v.hit = h;
    v.way = WAY_W'(w);
    v.vic = WAY_W'(vic);
    v.vv  = vv;
    v.vd  = vd;
    v.vt  = TAG_W'(vt);
    return v;
  endfunction

  function automatic vec_t with_fill(input vec_t vin, input int i, input int w, input int t, input bit d);
    vec_t v;
    v    = vin;
    v.fl = 1'b1;
    v.fi = SET_BITS'(i);
    v.fw = WAY_W'(w);
    v.ft = TAG_W'(t);
    v.fd = d;
    return v;
  endfunction

  function automatic vec_t with_ds(input vec_t vin, input int i, input int w);
    vec_t v;
    v    = vin;
    v.ds = 1'b1;
    v.di = SET_BITS'(i);
    v.dw = WAY_W'(w);
    return v;
  endfunction

  function automatic vec_t fl(input int i, input int w, input int t, input bit d);
    return with_fill(blank(), i, w, t, d);
  endfunction

  task automatic idle();
    inv_all = 1'b0; req_valid = 1'b0; fill_en = 1'b0; dirty_set_en = 1'b0;
  endtask

  // Advance one edge and check the response slot against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("r%0d rsp_valid", e.id), rsp_valid, 1);
      chk($sformatf("r%0d rsp_hit", e.id), rsp_hit, e.hit);
      chk($sformatf("r%0d rsp_way", e.id), rsp_way, e.way);
      chk($sformatf("r%0d rsp_victim", e.id), rsp_victim, e.vic);
      chk($sformatf("r%0d rsp_victim_valid", e.id), rsp_victim_valid, e.vv);
      if (e.vv) begin
        chk($sformatf("r%0d rsp_victim_dirty", e.id), rsp_victim_dirty, e.vd);
        chk($sformatf("r%0d rsp_victim_tag", e.id), rsp_victim_tag, e.vt);
      end
    end else begin
      chk("idle rsp_valid", rsp_valid, 0);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    req_valid = v.lk;  req_index = v.li;  req_tag = v.lt;
    fill_en = v.fl;    fill_index = v.fi; fill_way = v.fw; fill_tag = v.ft; fill_dirty = v.fd;
    dirty_set_en = v.ds; dirty_index = v.di; dirty_way = v.dw;
    if (v.lk) begin
      e = '{id: id, hit: v.hit, way: v.way, vic: v.vic, vv: v.vv, vd: v.vd, vt: v.vt};
      exp_q.push_back(e);
    end
    step();
    idle();
  endtask

  task automatic run_table();
    foreach (tbl[i]) apply(tbl[i], i);
  endtask

  // Count cycles with init_busy high (bounded). With inj set, pulse inv_all
  // mid-sweep and drive a fill + lookup that must both be ignored.
  task automatic count_busy(input bit inj, output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      inv_all    = inj && (n == 200);
      fill_en    = inj && (n == 300);
      fill_index = '0; fill_way = '0; fill_tag = TAG_W'(18'h77); fill_dirty = 1'b1;
      req_valid  = inj && (n == 300);
      req_index  = '0; req_tag = TAG_W'(18'h77);
      step();
    end
    idle();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " init_busy"}, init_busy, 1);
    chk({tag, " rsp_valid"}, rsp_valid, 0);
    chk({tag, " rsp_hit"}, rsp_hit, 0);
    chk({tag, " rsp_way"}, rsp_way, 0);
    chk({tag, " rsp_victim"}, rsp_victim, 0);
    chk({tag, " rsp_victim_valid"}, rsp_victim_valid, 0);
    chk({tag, " rsp_victim_dirty"}, rsp_victim_dirty, 0);
    chk({tag, " rsp_victim_tag"}, rsp_victim_tag, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and initial sweep.
    #2 reset = 1'b1;
    repeat (3) step();
    chk_reset_outs("reset");
    reset = 1'b0;
    count_busy(1'b1, nb);
    chk("sweep length after reset", nb, 512);

    // Phase 1: functional table.
    tbl.delete();
    tbl.push_back(lk(9'h1FF, 18'h3, 0, 0, 0, 0, 0, 0));              // 0 empty set
    tbl.push_back(lk(0, 18'h77, 0, 0, 0, 0, 0, 0));                  // 1 fill during sweep ignored
    for (int w = 0; w < 4; w++) tbl.push_back(fl(5, w, 18'h10 + w, 0));
    tbl.push_back(lk(5, 18'h12, 1, 2, 0, 1, 0, 18'h10));             // hit way 2
    tbl.push_back(lk(5, 18'h99, 0, 0, 0, 1, 0, 18'h10));             // miss
    for (int w = 0; w < 4; w++) tbl.push_back(fl(7, w, 18'h20 + w, 0));
    tbl.push_back(lk(7, 18'h20, 1, 0, 0, 1, 0, 18'h20));             // touch way 0
    tbl.push_back(lk(7, 18'h3FF, 0, 0, 2, 1, 0, 18'h22));            // PLRU victim way 2
    tbl.push_back(fl(9, 1, 18'h2A, 0));
    tbl.push_back(lk(9, 18'h2A, 1, 1, 0, 0, 0, 0));                  // lowest invalid is way 0
    tbl.push_back(with_ds(blank(), 9, 1));
    tbl.push_back(fl(9, 0, 18'h30, 0));
    tbl.push_back(fl(9, 2, 18'h32, 0));
    tbl.push_back(fl(9, 3, 18'h33, 0));
    tbl.push_back(lk(9, 18'h2A, 1, 1, 1, 1, 1, 18'h2A));
    tbl.push_back(lk(9, 18'h30, 1, 0, 2, 1, 0, 18'h32));
    tbl.push_back(lk(9, 18'h32, 1, 2, 2, 1, 0, 18'h32));
    tbl.push_back(lk(9, 18'h33, 1, 3, 1, 1, 1, 18'h2A));
    tbl.push_back(lk(9, 18'h1, 0, 0, 1, 1, 1, 18'h2A));              // dirty write-back victim
    tbl.push_back(with_fill(lk(3, 18'h55, BYP, 0, BYP ? 1 : 0, 0, 0, 0), 3, 0, 18'h55, 0));
    tbl.push_back(lk(3, 18'h55, 1, 0, 1, 0, 0, 0));
    tbl.push_back(with_ds(fl(11, 2, 18'h40, 0), 11, 2));             // fill beats dirty_set
    tbl.push_back(fl(11, 0, 18'h41, 0));
    tbl.push_back(fl(11, 1, 18'h42, 0));
    tbl.push_back(fl(11, 3, 18'h43, 0));
    tbl.push_back(lk(11, 18'h41, 1, 0, 0, 1, 0, 18'h41));
    tbl.push_back(lk(11, 18'h0, 0, 0, 2, 1, 0, 18'h40));
    for (int w = 0; w < 4; w++) tbl.push_back(fl(13, w, 18'h60 + w, 0));
    tbl.push_back(with_fill(lk(13, 18'h63, 1, 3, BYP ? 2 : 0, 1, 0, BYP ? 18'h62 : 18'h60),
                            13, 0, 18'h64, 0));                      // same-set: hit PLRU dropped
    tbl.push_back(lk(13, 18'h0, 0, 0, 2, 1, 0, 18'h62));
    tbl.push_back(with_fill(lk(5, 18'h10, 1, 0, 0, 1, 0, 18'h10), 15, 0, 18'h70, 0));
    tbl.push_back(lk(5, 18'h0, 0, 0, 3, 1, 0, 18'h13));              // hit PLRU applied
    tbl.push_back(lk(15, 18'h70, 1, 0, 1, 0, 0, 0));                 // fill applied
    run_table();

    // Interrupted sweep: inv_all, then reset at sweep cycle 100.
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    chk("busy after inv_all", init_busy, 1);
    repeat (99) step();
    reset = 1'b1;
    #1;
    chk_reset_outs("async reset");
    step();
    reset = 1'b0;
    exp_q.delete();
    count_busy(1'b0, nb);
    chk("sweep length after reset mid-sweep", nb, 512);

    // Phase 2: every earlier line must be gone.
    tbl.delete();
    tbl.push_back(lk(5, 18'h12, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(7, 18'h20, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(9, 18'h2A, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(3, 18'h55, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(11, 18'h40, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(13, 18'h64, 0, 0, 0, 0, 0, 0));
    tbl.push_back(lk(15, 18'h70, 0, 0, 0, 0, 0, 0));
    run_table();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_ram_nway.md
# tag_ram_nway

- Parametrised N-way set-associative tag store for the L1/L2 caches.
- Per set, holds tag, valid and dirty bits for every way plus tree-PLRU state.
- Performs a one-cycle registered lookup that returns hit way, victim way and victim tag/dirty.
- Self-invalidates via a hardware sweep after reset or on request, so cache controllers no longer rely on simulation-only RAM initialisation.

## Interface
Parameters:
- WAYS, 4, number of ways; power of two, 2..8; WAY_W = log2(WAYS).
- SET_BITS, 9, index width; sets = 2^SET_BITS.
- TAG_W, 18, tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init_busy  out  1  invalidation sweep in progress; lookups and fills ignored while high.
- inv_all  in  1  pulse; starts a full invalidation sweep.
- req_valid  in  1  lookup request.
- req_index  in  SET_BITS  lookup set.
- req_tag  in  TAG_W  lookup tag.
- rsp_valid  out  1  response valid, one cycle after an accepted request.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  WAY_W  hit way; 0 on miss.
- rsp_victim  out  WAY_W  replacement way.
- rsp_victim_valid  out  1  victim way holds a valid line.
- rsp_victim_dirty  out  1  victim way is dirty; write-back is required.
- rsp_victim_tag  out  TAG_W  victim tag, for forming the write-back address.
- fill_en  in  1  install a line.
- fill_index  in  SET_BITS  fill set.
- fill_way  in  WAY_W  fill way.
- fill_tag  in  TAG_W  fill tag.
- fill_dirty  in  1  dirty value written with the fill.
- dirty_set_en  in  1  mark an existing line dirty (store hit).
- dirty_index  in  SET_BITS  set for dirty_set_en.
- dirty_way  in  WAY_W  way for dirty_set_en.

## Operation
- **Storage:** per set and way: valid, dirty, tag. Per set: WAYS-1 tree-PLRU bits.
  - Node 0 is the root; node n has children 2n+1 and 2n+2.
  - A bit value of 0 means the LRU side is the lower half; 1 means the upper half.
- **State machine:** SWEEP and RUN.
  - Reset enters SWEEP with the counter at 0. inv_all in RUN also enters SWEEP with the counter at 0.
  - SWEEP: each cycle clears valid, dirty and PLRU of set[counter], then increments the counter.
  - Counter == 2^SET_BITS-1 completes that set and moves to RUN.
  - inv_all during SWEEP is ignored.
- **Lookup:** accepted when req_valid && !init_busy.
  - The response registers the compare against state as of the request edge.
  - Hit means a valid way with an equal tag. If several match (controller error), the lowest way wins.
  - Victim is the lowest-index invalid way. If no way is invalid, the victim is found by walking the PLRU bits from the root.
- **PLRU update:** on a hit, at the response edge, the path bits to rsp_way are set to point away from it. A fill updates the same way for fill_way.
  - Same set, same edge: the fill update applies and the hit update is dropped.
  - Different sets: both updates apply.
- **Fill:** writes tag, sets valid=1, and writes dirty=fill_dirty.
- **dirty_set_en:** sets the dirty bit only; valid and tag are unchanged.
  - If it targets the same set and way as a simultaneous fill, the fill wins.
- fill_en and dirty_set_en are ignored while init_busy.

## Timing
- **Reset values:**
  - init_busy=1.
  - rsp_valid=0, rsp_hit=0.
  - rsp_way=0, rsp_victim=0.
  - rsp_victim_valid=0, rsp_victim_dirty=0, rsp_victim_tag=0.
- **Sweep:** init_busy stays high for exactly 2^SET_BITS cycles after reset deasserts, or after the inv_all edge.
- **Lookup latency:** 1 cycle.
  - rsp_valid is a single-cycle pulse per accepted request.
  - Back-to-back requests are supported at one per cycle.
- **Fill/dirty visibility:** visible to lookups issued on the following edge.
- **Reset mid-operation:** asynchronously clears the outputs, forces SWEEP and restarts the counter at 0. In-flight responses are lost.

## Configuration
- **TAG_RAM_BYPASS_EN defined:**
  - A lookup whose req_index equals fill_index on the same edge as fill_en sees the post-fill set, for the compare, the victim and PLRU.
  - E.g. it hits on fill_tag.
- **Not defined:**
  - The lookup sees the pre-fill state.
  - The controller must not issue a same-set lookup and fill together.

## Test plan
All scenarios use WAYS=4, SET_BITS=9, TAG_W=18.
- **Reset sweep:** release reset → init_busy high for 512 cycles, low on cycle 513. A lookup of set 0x1FF, tag 0x3 → rsp_hit=0, rsp_victim=0, rsp_victim_valid=0.
- **Hit path:** fill set 5 ways 0..3 with tags 0x10..0x13. Lookup tag 0x12 → next cycle rsp_valid=1, rsp_hit=1, rsp_way=2.
- **PLRU order:** fill set 7 ways 0,1,2,3 in order, then look up the way-0 tag → victim lookup returns rsp_victim=2, rsp_victim_valid=1.
- **Dirty write-back:** fill set 9 way 1 with tag 0x2A and fill_dirty=0. Apply dirty_set_en to set 9 way 1, then fill ways 0, 2, 3 and look up tag 0x2A → hit. Make way 1 the PLRU victim → rsp_victim=1, rsp_victim_dirty=1, rsp_victim_tag=0x2A.
- **Same-edge fill + lookup:** fill set 3 way 0 with tag 0x55 while looking up set 3 tag 0x55 → rsp_hit=1 with TAG_RAM_BYPASS_EN; rsp_hit=0 without it.
- **Interrupted sweep:** assert inv_all, then at sweep cycle 100 assert reset for 1 cycle. init_busy stays high for 512 cycles after release, and earlier fills all miss.
